// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB scratch register file.
// Register indices are offsets from N_REGS, so they stay valid for any bank size.
package apb_slave_pkg;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_ACCESS
    } state_e;

    localparam int WAITCFG_IDX_OFS = 0;
    localparam int ID_IDX_OFS      = 1;

    localparam int WAITCFG_W = 4;

    // Same encoding as the AHB-side OKAY/ERROR response.
    localparam logic PSLVERR_OKAY  = 1'b0;
    localparam logic PSLVERR_ERROR = 1'b1;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB4 bus bundle between the bridge's master port and the register file.
// The clock and reset are kept outside the interface as plain ports.
interface apb_slave_regfile_if #(
    parameter int PADDR_SIZE = 8,
    parameter int PDATA_SIZE = 32
);

    logic                    PSEL;
    logic                    PENABLE;
    logic [2:0]              PPROT;
    logic                    PWRITE;
    logic [PDATA_SIZE/8-1:0] PSTRB;
    logic [PADDR_SIZE-1:0]   PADDR;
    logic [PDATA_SIZE-1:0]   PWDATA;
    logic [PDATA_SIZE-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PPROT, PWRITE, PSTRB, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PPROT, PWRITE, PSTRB, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_wait_gen.sv
// Loadable wait-state down-counter; doneNext_o flags the edge on which
// PREADY must rise so that exactly the loaded number of wait cycles is seen.
module apb_wait_gen
    import apb_slave_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [WAITCFG_W-1:0] loadVal_i,
    input  logic                 en_i,
    output logic                 doneNext_o
);

    logic [WAITCFG_W-1:0] cnt_q;
    logic [WAITCFG_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = loadVal_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign doneNext_o = en_i && (cnt_q == WAITCFG_W'(1));

endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 completer: byte-strobed scratch bank, WAITCFG wait-state register and
// read-only ID. Read data and error are decided at setup and held registered.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int          PADDR_SIZE  = 8,
    parameter int          PDATA_SIZE  = 32,
    parameter int          N_REGS      = 16,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_slave_regfile_if.slave  apb
);

    localparam int IDX_W = PADDR_SIZE - 2;
    localparam int NB    = PDATA_SIZE / 8;

    localparam logic [IDX_W-1:0]      WAITCFG_I = IDX_W'(N_REGS + WAITCFG_IDX_OFS);
    localparam logic [IDX_W-1:0]      ID_I      = IDX_W'(N_REGS + ID_IDX_OFS);
    localparam logic [PDATA_SIZE-1:0] ID_WORD   = PDATA_SIZE'(ID_VALUE);
    localparam logic [WAITCFG_W-1:0]  WAIT_RST  = WAITCFG_W'(WAIT_STATES);

    state_e                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  slvErr_q, slvErr_d;
    logic [PDATA_SIZE-1:0] rdData_q, rdData_d;
    logic [PDATA_SIZE-1:0] regs_q [N_REGS];
    logic [PDATA_SIZE-1:0] regs_d [N_REGS];
    logic [WAITCFG_W-1:0]  waitCfg_q, waitCfg_d;

    logic [IDX_W-1:0]      idx;
    logic [PDATA_SIZE-1:0] readVal;
    logic                  isScratch;
    logic                  accErr;
    logic                  waitLoad;
    logic                  waitEn;
    logic                  waitDone;
    logic                  unusedBits;

    assign idx        = apb.PADDR[PADDR_SIZE-1:2];
    assign unusedBits = ^{apb.PPROT[2:1], apb.PADDR[1:0]};

    always_comb begin
        readVal   = '0;
        isScratch = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                readVal   = regs_q[i];
                isScratch = 1'b1;
            end
        end
        if (idx == WAITCFG_I) begin
            readVal = PDATA_SIZE'(waitCfg_q);
        end
        if (idx == ID_I) begin
            readVal = ID_WORD;
        end

        accErr = PSLVERR_OKAY;
        if (!isScratch && (idx != WAITCFG_I) && (idx != ID_I)) begin
            accErr = PSLVERR_ERROR;
        end else if (apb.PWRITE && (idx == ID_I)) begin
            accErr = PSLVERR_ERROR;
        end else if (apb.PWRITE && (idx == WAITCFG_I) && !apb.PPROT[0]) begin
            accErr = PSLVERR_ERROR;
        end
    end

    // Writes land on the completion edge, using the error verdict taken at setup.
    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        slvErr_d  = slvErr_q;
        rdData_d  = rdData_q;
        regs_d    = regs_q;
        waitCfg_d = waitCfg_q;
        waitLoad  = 1'b0;
        waitEn    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d  = 1'b0;
                slvErr_d = PSLVERR_OKAY;
                rdData_d = '0;
                if (apb.PSEL && !apb.PENABLE) begin
                    state_d  = ST_ACCESS;
                    waitLoad = 1'b1;
                    ready_d  = (waitCfg_q == '0);
                    slvErr_d = accErr;
                    rdData_d = (apb.PWRITE || accErr) ? '0 : readVal;
                end
            end
            ST_ACCESS: begin
                if (!apb.PSEL) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                    slvErr_d = PSLVERR_OKAY;
                    rdData_d = '0;
                end else if (apb.PENABLE && ready_q) begin
                    if (apb.PWRITE && (slvErr_q == PSLVERR_OKAY)) begin
                        for (int i = 0; i < N_REGS; i++) begin
                            if (idx == IDX_W'(i)) begin
                                for (int b = 0; b < NB; b++) begin
                                    if (apb.PSTRB[b]) begin
                                        regs_d[i][8*b +: 8] = apb.PWDATA[8*b +: 8];
                                    end
                                end
                            end
                        end
                        if ((idx == WAITCFG_I) && apb.PSTRB[0]) begin
                            waitCfg_d = apb.PWDATA[WAITCFG_W-1:0];
                        end
                    end
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                    slvErr_d = PSLVERR_OKAY;
                    rdData_d = '0;
                end else if (apb.PENABLE) begin
                    waitEn  = 1'b1;
                    ready_d = waitDone;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            slvErr_q  <= PSLVERR_OKAY;
            rdData_q  <= '0;
            waitCfg_q <= WAIT_RST;
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            slvErr_q  <= slvErr_d;
            rdData_q  <= rdData_d;
            waitCfg_q <= waitCfg_d;
            regs_q    <= regs_d;
        end
    end

    apb_wait_gen uWaitGen (
        .clk_i      (PCLK),
        .rst_ni     (PRESETn),
        .load_i     (waitLoad),
        .loadVal_i  (waitCfg_q),
        .en_i       (waitEn),
        .doneNext_o (waitDone)
    );

    assign apb.PREADY  = ready_q;
    assign apb.PSLVERR = slvErr_q;
    assign apb.PRDATA  = rdData_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: directed vector table, randomized transfers
// against a register-map model, and abort/reset corner sequences.
module tb_apb_slave_regfile;

    localparam int          PADDR_SIZE  = 8;
    localparam int          PDATA_SIZE  = 32;
    localparam int          N_REGS      = 16;
    localparam int          WAIT_STATES = 2;
    localparam logic [31:0] ID_VALUE    = 32'hA5B0_0001;
    localparam int          WCFG        = N_REGS;
    localparam int          IDR         = N_REGS + 1;
    localparam int          MAX_WAIT    = 40;

    typedef struct {
        bit          wr;
        int          idx;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] expRdata;
        logic        expErr;
        int          expWaits;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] modelRegs [N_REGS];
    int          modelWait;

    vec_t vecs [19];

    apb_slave_regfile_if #(.PADDR_SIZE(PADDR_SIZE), .PDATA_SIZE(PDATA_SIZE)) bus ();

    apb_slave_regfile #(
        .PADDR_SIZE  (PADDR_SIZE),
        .PDATA_SIZE  (PDATA_SIZE),
        .N_REGS      (N_REGS),
        .WAIT_STATES (WAIT_STATES),
        .ID_VALUE    (ID_VALUE)
    ) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .apb     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N_REGS; i++) modelRegs[i] = 32'h0;
        modelWait = WAIT_STATES;
    endtask

    function automatic bit modelErr(input bit wr, input int idx, input logic [2:0] prot);
        if (idx > IDR) return 1'b1;
        if (wr && idx == IDR) return 1'b1;
        if (wr && idx == WCFG && !prot[0]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelRead(input int idx);
        if (idx < N_REGS) return modelRegs[idx];
        if (idx == WCFG)  return 32'(modelWait);
        if (idx == IDR)   return ID_VALUE;
        return 32'h0;
    endfunction

    task automatic modelWrite(input int idx, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] mask;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask[8*b +: 8] = 8'hFF;
        if (idx < N_REGS) modelRegs[idx] = (modelRegs[idx] & ~mask) | (data & mask);
        else if (idx == WCFG && strb[0]) modelWait = int'(data & 32'hF);
    endtask

    // Starts at a falling edge with the bus idle; returns at the falling edge after completion.
    task automatic applyStimulus(input bit wr, input int idx, input logic [31:0] data,
                                 input logic [3:0] strb, input logic [2:0] prot,
                                 output logic [31:0] rdata, output logic err, output int waits);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = 8'((idx << 2) | int'($urandom_range(0, 3)));
        bus.PWDATA  = data;
        bus.PSTRB   = strb;
        bus.PPROT   = prot;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        waits = 0;
        while (bus.PREADY !== 1'b1 && waits < MAX_WAIT) begin
            @(negedge clk);
            waits++;
        end
        if (bus.PREADY !== 1'b1) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL readyTimeout: PREADY still %b after %0d cycles, required 1", bus.PREADY, waits);
        end
        rdata = bus.PRDATA;
        err   = bus.PSLVERR;
        @(negedge clk);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        checkOutput("idleAfterDone", {29'b0, bus.PREADY, bus.PSLVERR, |bus.PRDATA}, 32'h0);
    endtask

    task automatic doXfer(input string name, input bit wr, input int idx, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot, output logic [31:0] rdata);
        logic        err;
        int          waits;
        bit          expErr;
        int          expWaits;
        logic [31:0] expRdata;
        expErr   = modelErr(wr, idx, prot);
        expWaits = modelWait;
        expRdata = (!wr && !expErr) ? modelRead(idx) : 32'h0;
        applyStimulus(wr, idx, data, strb, prot, rdata, err, waits);
        checkOutput({name, ".err"}, 32'(err), 32'(expErr));
        checkOutput({name, ".waits"}, 32'(waits), 32'(expWaits));
        if (!wr) checkOutput({name, ".rdata"}, rdata, expRdata);
        if (wr && !expErr) modelWrite(idx, data, strb);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          wt;

        vecs[0]  = '{1'b0, WCFG,      32'h0,         4'h0, 3'h0, 32'd2,         1'b0, 2};
        vecs[1]  = '{1'b0, IDR,       32'h0,         4'h0, 3'h0, 32'hA5B0_0001, 1'b0, 2};
        vecs[2]  = '{1'b0, 3,         32'h0,         4'hF, 3'h0, 32'h0,         1'b0, 2};
        vecs[3]  = '{1'b1, 5,         32'hDEAD_BEEF, 4'hF, 3'h0, 32'h0,         1'b0, 2};
        vecs[4]  = '{1'b1, 5,         32'h0000_1234, 4'h3, 3'h0, 32'h0,         1'b0, 2};
        vecs[5]  = '{1'b0, 5,         32'h0,         4'h0, 3'h0, 32'hDEAD_1234, 1'b0, 2};
        vecs[6]  = '{1'b1, WCFG,      32'h0,         4'hF, 3'h1, 32'h0,         1'b0, 2};
        vecs[7]  = '{1'b0, WCFG,      32'h0,         4'h0, 3'h0, 32'd0,         1'b0, 0};
        vecs[8]  = '{1'b1, WCFG,      32'd15,        4'h1, 3'h1, 32'h0,         1'b0, 0};
        vecs[9]  = '{1'b0, 5,         32'h0,         4'h0, 3'h0, 32'hDEAD_1234, 1'b0, 15};
        vecs[10] = '{1'b1, WCFG,      32'd7,         4'hF, 3'h0, 32'h0,         1'b1, 15};
        vecs[11] = '{1'b0, WCFG,      32'h0,         4'h0, 3'h0, 32'd15,        1'b0, 15};
        vecs[12] = '{1'b1, WCFG,      32'hFFFF_FFF1, 4'h1, 3'h1, 32'h0,         1'b0, 15};
        vecs[13] = '{1'b0, WCFG,      32'h0,         4'h0, 3'h0, 32'd1,         1'b0, 1};
        vecs[14] = '{1'b0, N_REGS+5,  32'h0,         4'h0, 3'h0, 32'h0,         1'b1, 1};
        vecs[15] = '{1'b1, IDR,       32'h0,         4'hF, 3'h1, 32'h0,         1'b1, 1};
        vecs[16] = '{1'b0, IDR,       32'h0,         4'h0, 3'h0, 32'hA5B0_0001, 1'b0, 1};
        vecs[17] = '{1'b1, 7,         32'hFFFF_FFFF, 4'h0, 3'h0, 32'h0,         1'b0, 1};
        vecs[18] = '{1'b0, 7,         32'h0,         4'h0, 3'h0, 32'h0,         1'b0, 1};

        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        bus.PSTRB   = '0;
        bus.PPROT   = '0;
        modelReset();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("resetOutputs", {29'b0, bus.PREADY, bus.PSLVERR, |bus.PRDATA}, 32'h0);

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].idx, vecs[i].data, vecs[i].strb, vecs[i].prot, rd, er, wt);
            checkOutput($sformatf("vec%0d.err", i), 32'(er), 32'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d.waits", i), 32'(wt), 32'(vecs[i].expWaits));
            if (!vecs[i].wr) checkOutput($sformatf("vec%0d.rdata", i), rd, vecs[i].expRdata);
            if (vecs[i].wr && !modelErr(vecs[i].wr, vecs[i].idx, vecs[i].prot))
                modelWrite(vecs[i].idx, vecs[i].data, vecs[i].strb);
        end

        for (int i = 0; i < 40; i++) begin
            int idx;
            idx = int'($urandom_range(0, N_REGS + 3));
            if ($urandom_range(0, 7) == 0) idx = 60;
            doXfer($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), idx, $urandom,
                   4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), rd);
        end

        doXfer("b2bWrite", 1'b1, 0, 32'h1, 4'hF, 3'h0, rd);
        doXfer("b2bRead", 1'b0, 0, 32'h0, 4'h0, 3'h0, rd);
        checkOutput("b2bValue", rd, 32'h1);

        doXfer("abortCfg", 1'b1, WCFG, 32'd4, 4'h1, 3'h1, rd);
        doXfer("abortPre", 1'b1, 1, 32'h1111_2222, 4'hF, 3'h0, rd);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 8'd4;
        bus.PWDATA  = 32'hFFFF_FFFF;
        bus.PSTRB   = 4'hF;
        bus.PPROT   = 3'h0;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        @(negedge clk);
        checkOutput("abortWaitReady", 32'(bus.PREADY), 32'h0);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checkOutput("abortReadyLow", 32'(bus.PREADY), 32'h0);
        end
        doXfer("abortRead", 1'b0, 1, 32'h0, 4'h0, 3'h0, rd);
        checkOutput("abortReg1", rd, 32'h1111_2222);

        doXfer("rstPre", 1'b1, 2, 32'h0000_0055, 4'hF, 3'h0, rd);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 8'd8;
        bus.PWDATA  = 32'hAAAA_AAAA;
        bus.PSTRB   = 4'hF;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("rstMidWait", {29'b0, bus.PREADY, bus.PSLVERR, |bus.PRDATA}, 32'h0);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        doXfer("rstReg2", 1'b0, 2, 32'h0, 4'h0, 3'h0, rd);
        checkOutput("rstReg2Value", rd, 32'h0);
        doXfer("rstCfg", 1'b0, WCFG, 32'h0, 4'h0, 3'h0, rd);

        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 8'(IDR << 2);
        @(negedge clk);
        bus.PENABLE = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rstReadyHigh", 32'(bus.PREADY), 32'h1);
        #2 rst_n = 1'b0;
        #1 checkOutput("rstAsyncClear", {29'b0, bus.PREADY, bus.PSLVERR, |bus.PRDATA}, 32'h0);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        doXfer("postRstId", 1'b0, IDR, 32'h0, 4'h0, 3'h0, rd);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
